// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: filler instruction, opcodes,
// fetch geometry and the instruction-pair record passed along the pipe.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int FETCH_WIDTH = 2;
  localparam int PC_STEP     = 8;

  typedef struct packed {
    logic            valid1;
    logic            valid2;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr1;
    logic [31:0]     instr2;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register that parks a returned instruction pair while
// decode is stalled, so the ROM result is never lost.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        flush,
  input  fetch_pair_t d,
  output fetch_pair_t q
);

  // Flush (redirect) and clear (pair consumed) both empty the entry; load parks a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush || clear) begin
      q.valid1 <= 1'b0;
      q.valid2 <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch front end: owns the PC, addresses the two-wide ROM,
// absorbs its one-cycle read latency and tags each pair with PCs and valids.
module fetch_unit
  import riscv_pkg::XLEN, riscv_pkg::PC_STEP, riscv_pkg::fetch_pair_t;
#(
  parameter int          PC_WIDTH   = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_instr1,
  input  logic [31:0]           rom_instr2,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid1,
  output logic                  out_valid2,
  output logic [PC_WIDTH-1:0]   out_pc1,
  output logic [PC_WIDTH-1:0]   out_pc2,
  output logic [31:0]           out_instr1,
  output logic [31:0]           out_instr2
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] last_pc_q;
  logic                inflight_valid_q;
  logic [PC_WIDTH-1:0] inflight_pc_q;
  logic                issue;
  logic                skid_load;
  logic                skid_clear;
  fetch_pair_t         rom_pair;
  fetch_pair_t         skid_q;
  fetch_pair_t         sel;

  // A redirect target is fetched in the same cycle it arrives; low PC bits are ignored.
  assign fetch_pc = (redirect_valid ? redirect_pc : pc_q) & ~PC_WIDTH'(3);
  assign rom_addr = fetch_pc[ADDR_WIDTH+1:2];
  assign issue    = !stall;

  // PC and in-flight request tracking; a held address never produces a valid pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= '0;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
    end else if (issue) begin
      inflight_valid_q <= 1'b1;
      inflight_pc_q    <= fetch_pc;
      pc_q             <= fetch_pc + PC_WIDTH'(PC_STEP);
    end else begin
      inflight_valid_q <= 1'b0;
      if (redirect_valid) begin
        pc_q <= fetch_pc;
      end
    end
  end

  // Park the ROM pair when decode stalls; a redirect squashes rather than parks.
  assign skid_load  = stall && !skid_q.valid1 && inflight_valid_q && !redirect_valid;
  assign skid_clear = skid_q.valid1 && !stall;

  fetch_skid_buffer u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .flush (redirect_valid),
    .d     (rom_pair),
    .q     (skid_q)
  );

  // Tag ROM data with its PC; the last ROM word has no successor so slot 2 is dropped there.
  always_comb begin
    rom_pair        = '0;
    rom_pair.valid1 = inflight_valid_q;
    rom_pair.valid2 = inflight_valid_q &&
                      (inflight_pc_q[ADDR_WIDTH+1:2] != {ADDR_WIDTH{1'b1}});
    rom_pair.pc     = XLEN'(inflight_pc_q);
    rom_pair.instr1 = rom_instr1;
    rom_pair.instr2 = rom_instr2;
  end

  // Skid contents win over fresh ROM data; a redirect kills whatever is shown.
  always_comb begin
    sel        = skid_q.valid1 ? skid_q : rom_pair;
    out_valid1 = sel.valid1 && !redirect_valid;
    out_valid2 = sel.valid2 && !redirect_valid;
    out_instr1 = out_valid1 ? sel.instr1 : NOP_INSTR;
    out_instr2 = out_valid2 ? sel.instr2 : NOP_INSTR;
    out_pc1    = sel.valid1 ? PC_WIDTH'(sel.pc) : last_pc_q;
    out_pc2    = out_pc1 + PC_WIDTH'(4);
  end

  // Remember the last presented PC so bubbles keep a stable PC on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc_q <= '0;
    end else if (sel.valid1) begin
      last_pc_q <= PC_WIDTH'(sel.pc);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a registered two-port ROM model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_instr1;
  logic [31:0] rom_instr2;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid1;
  logic        out_valid2;
  logic [31:0] out_pc1;
  logic [31:0] out_pc2;
  logic [31:0] out_instr1;
  logic [31:0] out_instr2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        v1;
    logic        v2;
    logic        chk_pc;
    logic [31:0] pc1;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [9:0]  addr;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] rom [0:1023];

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_WIDTH   (32),
    .ADDR_WIDTH (10),
    .NOP_INSTR  (32'h00000013)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr1     (rom_instr1),
    .rom_instr2     (rom_instr2),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid1     (out_valid1),
    .out_valid2     (out_valid2),
    .out_pc1        (out_pc1),
    .out_pc2        (out_pc2),
    .out_instr1     (out_instr1),
    .out_instr2     (out_instr2)
  );

  // Registered ROM: both words appear one cycle after the address; word 1023's successor wraps.
  always @(posedge clk) begin
    rom_instr1 <= rom[rom_addr];
    rom_instr2 <= rom[rom_addr + 10'd1];
  end

  function automatic logic [31:0] romWord(input int i);
    logic [31:0] w;
    if (i == 0)      w = 32'h00100293;
    else if (i == 1) w = 32'h00200313;
    else             w = 32'h00A00033 | (32'(i) << 7);
    return w;
  endfunction

  function automatic void addVec(input logic s, input logic rv, input logic [31:0] rpc,
                                 input logic v1, input logic v2, input logic chk_pc,
                                 input logic [31:0] pc1, input logic [31:0] i1,
                                 input logic [31:0] i2, input logic [9:0] addr);
    vec_t v;
    v.stall = s; v.rv = rv; v.rpc = rpc; v.v1 = v1; v.v2 = v2; v.chk_pc = chk_pc;
    v.pc1 = pc1; v.i1 = i1; v.i2 = i2; v.addr = addr;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic v1, input logic v2,
                             input logic chk_pc, input logic [31:0] pc1,
                             input logic [31:0] i1, input logic [31:0] i2,
                             input logic [9:0] addr);
    logic ok;
    checks++;
    ok = (out_valid1 === v1) && (out_valid2 === v2) && (out_instr1 === i1) &&
         (out_instr2 === i2) && (rom_addr === addr);
    if (chk_pc) ok = ok && (out_pc1 === pc1) && (out_pc2 === pc1 + 32'd4);
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got v=%b%b pc=%h/%h i=%h/%h addr=%0d, want v=%b%b pc=%h(chk %b) i=%h/%h addr=%0d",
               name, out_valid1, out_valid2, out_pc1, out_pc2, out_instr1, out_instr2, rom_addr,
               v1, v2, pc1, chk_pc, i1, i2, addr);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = romWord(i);

    // Free run, 3-cycle stall on pair 0x10, then redirects (aligned, odd word, wrap, low bits set).
    addVec(0, 0, 32'h0,   0, 0, 1, 32'h0,    NOP,          NOP,          10'd0);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h0,    romWord(0),   romWord(1),   10'd2);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h8,    romWord(2),   romWord(3),   10'd4);
    addVec(1, 0, 32'h0,   1, 1, 1, 32'h10,   romWord(4),   romWord(5),   10'd6);
    addVec(1, 0, 32'h0,   1, 1, 1, 32'h10,   romWord(4),   romWord(5),   10'd6);
    addVec(1, 0, 32'h0,   1, 1, 1, 32'h10,   romWord(4),   romWord(5),   10'd6);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h10,   romWord(4),   romWord(5),   10'd6);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h18,   romWord(6),   romWord(7),   10'd8);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h20,   romWord(8),   romWord(9),   10'd10);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h28,   romWord(10),  romWord(11),  10'd12);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h30,   romWord(12),  romWord(13),  10'd14);
    addVec(0, 1, 32'h20,  0, 0, 0, 32'h0,    NOP,          NOP,          10'd8);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h20,   romWord(8),   romWord(9),   10'd10);
    addVec(0, 1, 32'h14,  0, 0, 0, 32'h0,    NOP,          NOP,          10'd5);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h14,   romWord(5),   romWord(6),   10'd7);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h1C,   romWord(7),   romWord(8),   10'd9);
    addVec(0, 1, 32'hFFC, 0, 0, 0, 32'h0,    NOP,          NOP,          10'd1023);
    addVec(0, 0, 32'h0,   1, 0, 1, 32'hFFC,  romWord(1023), NOP,         10'd1);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h1004, romWord(1),   romWord(2),   10'd3);
    addVec(0, 1, 32'h23,  0, 0, 0, 32'h0,    NOP,          NOP,          10'd8);
    addVec(0, 0, 32'h0,   1, 1, 1, 32'h20,   romWord(8),   romWord(9),   10'd10);

    // Reset state
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset", 0, 0, 1, 32'h0, NOP, NOP, 10'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].stall, vecs[k].rv, vecs[k].rpc);
      checkOutput($sformatf("vec%0d", k), vecs[k].v1, vecs[k].v2, vecs[k].chk_pc,
                  vecs[k].pc1, vecs[k].i1, vecs[k].i2, vecs[k].addr);
    end

    // Redirect and stall together: target is remembered but not issued until release
    applyStimulus(1, 1, 32'h40);
    checkOutput("redir_stall", 0, 0, 0, 32'h0, NOP, NOP, 10'd16);
    applyStimulus(1, 0, 32'h0);
    checkOutput("redir_stall_hold", 0, 0, 0, 32'h0, NOP, NOP, 10'd16);
    applyStimulus(0, 0, 32'h0);
    checkOutput("redir_stall_release", 0, 0, 0, 32'h0, NOP, NOP, 10'd16);
    applyStimulus(1, 0, 32'h0);
    checkOutput("target_shown", 1, 1, 1, 32'h40, romWord(16), romWord(17), 10'd18);
    applyStimulus(1, 0, 32'h0);
    checkOutput("target_skid", 1, 1, 1, 32'h40, romWord(16), romWord(17), 10'd18);

    // Asynchronous reset while the skid is occupied
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midstream_reset", 0, 0, 1, 32'h0, NOP, NOP, 10'd0);
    stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 32'h0);
    checkOutput("restart_c0", 0, 0, 1, 32'h0, NOP, NOP, 10'd0);
    applyStimulus(0, 0, 32'h0);
    checkOutput("restart_c1", 1, 1, 1, 32'h0, romWord(0), romWord(1), 10'd2);
    applyStimulus(0, 0, 32'h0);
    checkOutput("restart_c2", 1, 1, 1, 32'h8, romWord(2), romWord(3), 10'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
